// File: rtl/uart_rx_apb_if.sv
// APB3 register block for the UART receiver: arms the receiver, captures frames,
// checks parity/stop bits and reports data, status and a level interrupt.
module uart_rx_apb_if #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter logic        PAR_ODD_RST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pSel,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [ADDR_W-1:0] pAddr,
  input  logic [DATA_W-1:0] pWData,
  output logic [DATA_W-1:0] pRData,
  output logic              pReady,
  output logic              pSlvErr,
  input  logic [10:0]       rxData,
  input  logic              store,
  input  logic              clrRxStartBit,
  output logic              rxStart,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(4'h0);
  localparam logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(4'h4);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(4'h8);

  // Register state
  logic              rx_start_q, rx_start_d;
  logic              par_odd_q, par_odd_d;
  logic              int_en_q, int_en_d;
  logic [7:0]        data_q, data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              par_err_q, par_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              store_q, store_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  // Bus decode and frame-capture qualifiers
  logic              setup_c, access_c;
  logic              sel_ctrl_c, sel_data_c, sel_status_c;
  logic              bus_err_c, acc_ok_c;
  logic              wr_ctrl_c, wr_status_c, pop_c;
  logic              capture_c, par_bad_c, frame_bad_c;
  logic [DATA_W-1:0] rdata_c;
  logic              unused_c;

  assign setup_c      = pSel & ~pEnable;
  assign access_c     = pSel & pEnable;
  assign sel_ctrl_c   = (pAddr == ADDR_CTRL);
  assign sel_data_c   = (pAddr == ADDR_DATA);
  assign sel_status_c = (pAddr == ADDR_STATUS);

  // Misaligned, unmapped and DATA-write accesses are refused with no side effect
  assign bus_err_c = (pAddr[1:0] != 2'b00)
                   | ~(sel_ctrl_c | sel_data_c | sel_status_c)
                   | (pWrite & sel_data_c);
  assign acc_ok_c    = access_c & ~bus_err_c;
  assign wr_ctrl_c   = acc_ok_c & pWrite & sel_ctrl_c;
  assign wr_status_c = acc_ok_c & pWrite & sel_status_c;
  assign pop_c       = acc_ok_c & ~pWrite & sel_data_c;

  // One capture per frame on the rising edge of the store level
  assign capture_c   = store & ~store_q;
  assign par_bad_c   = (^rxData[9:1]) != par_odd_q;
  assign frame_bad_c = ~rxData[10] | rxData[0];

  assign unused_c = ^pWData[DATA_W-1:4];

  // Read mux for the addressed register; unused bits read 0
  always_comb begin
    rdata_c = '0;
    if (sel_ctrl_c) begin
      rdata_c = DATA_W'({int_en_q, par_odd_q, rx_start_q});
    end else if (sel_data_c) begin
      rdata_c = DATA_W'(data_q);
    end else if (sel_status_c) begin
      rdata_c = DATA_W'({overrun_q, frame_err_q, par_err_q, rx_valid_q});
    end
  end

  // Next-state logic; APB write beats rxStart clear, error set beats W1C
  always_comb begin
    rx_start_d  = rx_start_q;
    par_odd_d   = par_odd_q;
    int_en_d    = int_en_q;
    data_d      = data_q;
    rx_valid_d  = rx_valid_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    store_d     = store;
    prdata_d    = prdata_q;
    pslverr_d   = 1'b0;
    irq_d       = int_en_q & (rx_valid_q | par_err_q | frame_err_q | overrun_q);

    if (setup_c) begin
      prdata_d  = bus_err_c ? '0 : rdata_c;
      pslverr_d = bus_err_c;
    end

    if (wr_ctrl_c) begin
      rx_start_d = pWData[0];
      par_odd_d  = pWData[1];
      int_en_d   = pWData[2];
    end else if (clrRxStartBit) begin
      rx_start_d = 1'b0;
    end

    if (wr_status_c) begin
      if (pWData[1]) par_err_d   = 1'b0;
      if (pWData[2]) frame_err_d = 1'b0;
      if (pWData[3]) overrun_d   = 1'b0;
    end

    if (pop_c) begin
      rx_valid_d = 1'b0;
    end

    if (capture_c) begin
      data_d     = rxData[8:1];
      rx_valid_d = 1'b1;
      if (rx_valid_q && !pop_c) overrun_d   = 1'b1;
      if (par_bad_c)            par_err_d   = 1'b1;
      if (frame_bad_c)          frame_err_d = 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_start_q  <= 1'b0;
      par_odd_q   <= PAR_ODD_RST;
      int_en_q    <= 1'b0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      store_q     <= 1'b0;
      irq_q       <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
    end else begin
      rx_start_q  <= rx_start_d;
      par_odd_q   <= par_odd_d;
      int_en_q    <= int_en_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      store_q     <= store_d;
      irq_q       <= irq_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
    end
  end

  assign pRData  = prdata_q;
  assign pSlvErr = pslverr_q;
  assign pReady  = 1'b1;
  assign rxStart = rx_start_q;
  assign irq     = irq_q;

endmodule

// File: doc/uart_rx_apb_if.md
Name: uart_rx_apb_if

Overview:
APB3 slave register block directly downstream of the UART receiver core. It arms the receiver via rxStart and captures each 11-bit frame when the receiver raises store. It acknowledges clrRxStartBit, checks parity and stop bit, and exposes data, status and an interrupt to the bus.

Parameters:
ADDR_W, 4, APB address width (byte address, word-aligned registers)
DATA_W, 32, APB data width
PAR_ODD_RST, 0, reset value of CTRL.parOdd (0 = even parity)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
pSel  input  1  APB select
pEnable  input  1  APB enable (access phase)
pWrite  input  1  1 = write, 0 = read
pAddr  input  ADDR_W  byte address
pWData  input  DATA_W  write data
pRData  output  DATA_W  read data, registered
pReady  output  1  tied 1 (zero wait states)
pSlvErr  output  1  error response, valid in access phase
rxData  input  11  frame from receiver core: [0] start, [8:1] data LSB-first, [9] parity, [10] stop
store  input  1  receiver frame-complete level, held for one or more cycles
clrRxStartBit  input  1  receiver request to clear rxStart (1-cycle pulse)
rxStart  output  1  arms receiver (CTRL bit0)
irq  output  1  interrupt, level

Behaviour:
- Reset is asynchronous, active-high. Outputs during and after reset: rxStart=0, pRData=0, pSlvErr=0, irq=0. Internal state after reset: CTRL={intEn=0, parOdd=PAR_ODD_RST, rxStart=0}, DATA=0, STATUS=0, storeD=0.
- Register map:
  - 0x0 CTRL RW: [0] rxStart, [1] parOdd, [2] intEn.
  - 0x4 DATA RO: [7:0] byte. A read pops the byte (clears rxValid).
  - 0x8 STATUS: [0] rxValid RO; [1] parErr, [2] frameErr, [3] overrun, each write-1-to-clear.
  - Unused bits read 0.
- APB decode:
  - Setup phase is pSel&!pEnable; access phase is pSel&pEnable.
  - pRData is loaded in the setup phase from the addressed register, so it is stable throughout the access phase.
  - Writes and read side effects commit at the end of the access phase.
  - pSlvErr=1 in the access phase for address 0xC, for a write to DATA, or for a misaligned address (pAddr[1:0]≠0). An erroring access has no side effect.
- Capture:
  - storeD registers store.
  - capture = store & !storeD, so there is exactly one capture per frame however long store is held.
  - On capture: DATA ← rxData[8:1]; rxValid ← 1.
  - parErr is set if ^rxData[9:1] ≠ parOdd.
  - frameErr is set if rxData[10]=0 or rxData[0]=1.
- Overrun: capture while rxValid=1 and no DATA pop in the same cycle → overrun ← 1; DATA is overwritten with the new byte.
- rxStart handshake: clrRxStartBit clears CTRL.rxStart one cycle later.
- irq = intEn & (rxValid | parErr | frameErr | overrun), registered, so it has 1-cycle latency.
- Simultaneous events:
  - capture + DATA pop in the same cycle: rxValid stays 1, new byte is kept, no overrun.
  - clrRxStartBit + CTRL write in the same cycle: the APB write value wins, so re-arm is not lost.
  - W1C of an error bit + the same error set by capture in the same cycle: the set wins.
- Reset asserted mid-frame or mid-transfer: all state returns to reset values immediately. Frame capture is lost; no partial update.

Test Plan:
- Reset: assert rst while store=1 → rxStart=0, irq=0, all registers read 0 except CTRL.parOdd=PAR_ODD_RST after release.
- Arm and capture: write CTRL=0x5; rxStart=1. Drive rxData=11'b1_0_10100101_0 (data 0xA5, even parity 0, stop 1), store high 3 cycles, then clrRxStartBit pulse. Required response: STATUS=0x1; DATA reads 0xA5; STATUS afterwards 0x0; rxStart=0; irq rose 1 cycle after capture and fell after the pop.
- Errors: frame with data 0x01, parity 0 (even), stop 0 → STATUS=0x7. Write STATUS=0x6 → STATUS=0x1.
- Overrun: two captures with no read, bytes 0x11 then 0x22 → DATA=0x22, STATUS[3]=1. Capture 0x33 in the same cycle as a DATA pop → STATUS=0x1, no overrun, DATA=0x33.
- Bus errors: read 0xC, write 0x4, and access 0x2 → pSlvErr=1 in the access phase, registers unchanged. Normal accesses → pSlvErr=0, pReady=1.
- Race: CTRL write 0x1 in the same cycle as clrRxStartBit → rxStart=1. Same-cycle W1C of parErr and a new parity error → parErr=1.
